multi_channel_dma: RTL and testbench

MULTI_CHANNEL_DMA -- requirements
Module: multi_channel_dma

---
 rtl/multi_channel_dma.sv | 139 +++++++++++++
 tb/tb_multi_channel_dma.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_dma.sv
// Multi-channel memory-to-memory DMA engine.
// Each channel holds a source, a destination and a word count. A round-robin
// arbiter hands the single memory port to one busy channel at a time, and that
// channel copies one word (read, then write) before the next arbitration.
module multi_channel_dma #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_start,
   input  logic [NUM_CH*ADDR_W-1:0] ch_src,
   input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
   input  logic [NUM_CH*LEN_W-1:0]  ch_len,
   output logic [NUM_CH-1:0]        ch_busy,
   output logic [NUM_CH-1:0]        ch_done,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {ARB, RD, WR} state_t;

   state_t            state;
   // Channel currently owning the port; doubles as the round-robin "last granted" pointer.
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   next_grant;
   logic [CH_W-1:0]   hi_idx;
   logic [CH_W-1:0]   lo_idx;
   logic              hi_found;
   logic              lo_found;

   logic [ADDR_W-1:0] src_q [NUM_CH];
   logic [ADDR_W-1:0] dst_q [NUM_CH];
   logic [LEN_W-1:0]  len_q [NUM_CH];

   // Round-robin pick: first busy channel above the last grant, otherwise the first busy one from 0.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_busy[i]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = CH_W'(i);
            end
            if (!hi_found && (i > int'(grant))) begin
               hi_found = 1'b1;
               hi_idx   = CH_W'(i);
            end
         end
      end
      next_grant = hi_found ? hi_idx : lo_idx;
   end

   // Channel bookkeeping and the ARB/RD/WR sequencer share one block because a WR ack updates the granted channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB;
         grant     <= CH_W'(NUM_CH - 1);
         ch_busy   <= '0;
         ch_done   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         // NOTE: the channel register arrays are reset as well, because a reset must leave every channel counter cleared.
         for (int i = 0; i < NUM_CH; i++) begin
            src_q[i] <= '0;
            dst_q[i] <= '0;
            len_q[i] <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register here samples pre-edge values.
         ch_done <= '0;

         // Accept starts on idle channels; a zero-length start completes immediately without touching memory.
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_start[i] && !ch_busy[i]) begin
               if (ch_len[i*LEN_W +: LEN_W] != '0) begin
                  src_q[i]   <= ch_src[i*ADDR_W +: ADDR_W];
                  dst_q[i]   <= ch_dst[i*ADDR_W +: ADDR_W];
                  len_q[i]   <= ch_len[i*LEN_W +: LEN_W];
                  ch_busy[i] <= 1'b1;
               end else begin
                  ch_done[i] <= 1'b1;
               end
            end
         end

         case (state)
            ARB: begin
               if (|ch_busy) begin
                  grant    <= next_grant;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= src_q[next_grant];
                  state    <= RD;
               end
            end
            RD: begin
               // mem_wdata is the word buffer: the read word is parked there for the write.
               if (mem_ack) begin
                  mem_wdata <= mem_rdata;
                  mem_we    <= 1'b1;
                  mem_addr  <= dst_q[grant];
                  state     <= WR;
               end
            end
            WR: begin
               if (mem_ack) begin
                  mem_req      <= 1'b0;
                  mem_we       <= 1'b0;
                  src_q[grant] <= src_q[grant] + ADDR_W'(1);
                  dst_q[grant] <= dst_q[grant] + ADDR_W'(1);
                  len_q[grant] <= len_q[grant] - LEN_W'(1);
                  if (len_q[grant] == LEN_W'(1)) begin
                     ch_busy[grant] <= 1'b0;
                     ch_done[grant] <= 1'b1;
                  end
                  state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_channel_dma.sv
// Self-checking bench for multi_channel_dma.
// A memory responder with programmable ack latency serves the DUT port and logs
// every accepted access; a transfer-level reference model predicts the ordered
// list of accesses and data from the round-robin rule and a shadow memory.
module tb_multi_channel_dma;

   localparam int NUM_CH = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_CH-1:0]        ch_start = '0;
   logic [NUM_CH*ADDR_W-1:0] ch_src = '0;
   logic [NUM_CH*ADDR_W-1:0] ch_dst = '0;
   logic [NUM_CH*LEN_W-1:0]  ch_len = '0;
   logic [NUM_CH-1:0]        ch_busy;
   logic [NUM_CH-1:0]        ch_done;
   logic                     mem_req;
   logic                     mem_we;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic [DATA_W-1:0]        mem_rdata = '0;
   logic                     mem_ack = 1'b0;

   multi_channel_dma #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .reset(reset),
      .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
      .ch_busy(ch_busy), .ch_done(ch_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // ---------------- memories ----------------
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   logic [31:0] dut_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   acc_t        seen[$];
   acc_t        exp_q[$];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] dut_rd(input logic [31:0] a);
      return dut_mem.exists(a) ? dut_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // ---------------- memory responder ----------------
   int unsigned min_delay = 0;
   int unsigned max_delay = 0;
   bit          ack_wr_en = 1'b1;

   initial begin
      bit          pending;
      int unsigned wait_left;
      logic        s_we;
      logic [31:0] s_addr;
      logic [31:0] s_wdata;
      acc_t        a;
      pending   = 1'b0;
      wait_left = 0;
      forever begin
         @(negedge clk);
         if (mem_req && !reset) begin
            if (!pending) begin
               pending   = 1'b1;
               wait_left = $urandom_range(max_delay, min_delay);
               s_we      = mem_we;
               s_addr    = mem_addr;
               s_wdata   = mem_wdata;
            end else begin
               check("hold_we", mem_we, s_we);
               check("hold_addr", mem_addr, s_addr);
               if (s_we) check("hold_wdata", mem_wdata, s_wdata);
            end
            if (wait_left == 0 && (ack_wr_en || !mem_we)) begin
               mem_ack = 1'b1;
               a.we    = mem_we;
               a.addr  = mem_addr;
               if (mem_we) begin
                  dut_mem[mem_addr] = mem_wdata;
                  a.data = mem_wdata;
               end else begin
                  mem_rdata = dut_rd(mem_addr);
                  a.data    = mem_rdata;
               end
               seen.push_back(a);
               pending = 1'b0;
            end else begin
               mem_ack = 1'b0;
               if (wait_left > 0) wait_left--;
            end
         end else begin
            // Random acks and garbage data while idle: the DUT must ignore them.
            pending   = 1'b0;
            mem_ack   = 1'($urandom_range(1, 0));
            mem_rdata = $urandom;
         end
      end
   end

   // ---------------- transfer-level reference model ----------------
   logic [NUM_CH-1:0] t_mask;
   logic [31:0]       t_src [NUM_CH];
   logic [31:0]       t_dst [NUM_CH];
   int                t_len [NUM_CH];
   int                m_last = NUM_CH - 1;
   int                last_done_cyc [NUM_CH];

   // All masked channels start together; words are served one per grant in rotation after the last grant.
   task automatic build_expected();
      logic [31:0] ms [NUM_CH];
      logic [31:0] md [NUM_CH];
      int          ml [NUM_CH];
      bit          found;
      acc_t        a;
      exp_q.delete();
      for (int c = 0; c < NUM_CH; c++) begin
         ms[c] = t_src[c];
         md[c] = t_dst[c];
         ml[c] = t_mask[c] ? t_len[c] : 0;
      end
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_last + k) % NUM_CH;
            if (!found && ml[c] > 0) begin
               found  = 1'b1;
               a.we   = 1'b0;
               a.addr = ms[c];
               a.data = ref_rd(ms[c]);
               exp_q.push_back(a);
               a.we   = 1'b1;
               a.addr = md[c];
               exp_q.push_back(a);
               ref_mem[md[c]] = a.data;
               ms[c]  = ms[c] + 32'd1;
               md[c]  = md[c] + 32'd1;
               ml[c]  = ml[c] - 1;
               m_last = c;
            end
         end
      end
   endtask

   // Start the masked channels, optionally re-pulse start mid-transfer, wait for completion and compare.
   task automatic run_xfer(input string tag, input int restart_cyc);
      int done_cnt [NUM_CH];
      int cyc;
      bit finished;
      bit all_done;
      logic [NUM_CH-1:0] exp_busy;
      build_expected();
      seen.delete();
      for (int c = 0; c < NUM_CH; c++) begin
         done_cnt[c]      = 0;
         last_done_cyc[c] = -1;
         exp_busy[c]      = t_mask[c] && (t_len[c] != 0);
      end
      @(negedge clk);
      ch_start = t_mask;
      for (int c = 0; c < NUM_CH; c++) begin
         ch_src[c*ADDR_W +: ADDR_W] = t_src[c];
         ch_dst[c*ADDR_W +: ADDR_W] = t_dst[c];
         ch_len[c*LEN_W +: LEN_W]   = LEN_W'(t_len[c]);
      end
      cyc      = 0;
      finished = 1'b0;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         ch_start = '0;
         if (cyc == 1) check({tag, "_busy_after_start"}, ch_busy, exp_busy);
         if (cyc == restart_cyc) begin
            ch_start = t_mask;
            for (int c = 0; c < NUM_CH; c++) begin
               ch_src[c*ADDR_W +: ADDR_W] = ~t_src[c];
               ch_dst[c*ADDR_W +: ADDR_W] = ~t_dst[c];
               ch_len[c*LEN_W +: LEN_W]   = LEN_W'(7);
            end
         end
         all_done = 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_done[c]) begin
               done_cnt[c]++;
               last_done_cyc[c] = cyc;
            end
            if (t_mask[c] && done_cnt[c] == 0) all_done = 1'b0;
         end
         if (all_done && ch_busy == '0) finished = 1'b1;
      end
      check({tag, "_completed_in_budget"}, finished, 1'b1);
      check({tag, "_access_count"}, seen.size(), exp_q.size());
      for (int i = 0; i < seen.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s_acc%0d_we", tag, i), seen[i].we, exp_q[i].we);
         check($sformatf("%s_acc%0d_addr", tag, i), seen[i].addr, exp_q[i].addr);
         check($sformatf("%s_acc%0d_data", tag, i), seen[i].data, exp_q[i].data);
      end
      for (int c = 0; c < NUM_CH; c++)
         check($sformatf("%s_done_pulses_ch%0d", tag, c), done_cnt[c], t_mask[c] ? 1 : 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b0;
      m_last = NUM_CH - 1;
   endtask

   task automatic set_ch(input int c, input logic [31:0] s, input logic [31:0] d, input int n);
      t_src[c] = s;
      t_dst[c] = d;
      t_len[c] = n;
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int req_cycles;
      int dones;
      bit reached_wr;

      // Reset state
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", ch_busy, '0);
      check("rst_done", ch_done, '0);
      check("rst_req", mem_req, 1'b0);
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, '0);
      check("rst_wdata", mem_wdata, '0);
      reset = 1'b0;

      // Single channel copy, ack always immediate: done 12 cycles after busy rises
      set_ch(0, 32'h10, 32'h80, 4);
      set_ch(1, 32'h0, 32'h0, 0);
      t_mask = 2'b01;
      run_xfer("basic", 0);
      check("basic_first_read_addr", seen.size() > 0 ? seen[0].addr : 32'hDEAD, 32'h10);
      check("basic_last_write_addr", seen.size() > 7 ? seen[7].addr : 32'hDEAD, 32'h83);
      check("basic_done_latency", last_done_cyc[0] - 1, 12);

      // Two channels together after reset: ch0 first, then alternate
      do_reset();
      set_ch(0, 32'h1000, 32'h2000, 2);
      set_ch(1, 32'h3000, 32'h4000, 2);
      t_mask = 2'b11;
      run_xfer("dual", 0);
      check("dual_word0_ch0", seen.size() > 0 ? seen[0].addr : 32'hDEAD, 32'h1000);
      check("dual_word1_ch1", seen.size() > 2 ? seen[2].addr : 32'hDEAD, 32'h3000);
      check("dual_word2_ch0", seen.size() > 4 ? seen[4].addr : 32'hDEAD, 32'h1001);

      // Zero-length start: immediate done, no memory traffic
      set_ch(1, 32'h5000, 32'h6000, 0);
      t_mask = 2'b10;
      run_xfer("zero_len", 0);
      check("zero_len_done_next_cycle", last_done_cyc[1], 1);
      req_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req) req_cycles++;
      end
      check("zero_len_no_req", req_cycles, 0);

      // Three-cycle ack latency on every access
      min_delay = 3;
      max_delay = 3;
      set_ch(0, 32'h700, 32'h900, 3);
      t_mask = 2'b01;
      run_xfer("slow_ack", 0);
      min_delay = 0;
      max_delay = 0;

      // Source address wraps
      set_ch(0, 32'hFFFF_FFFF, 32'hA00, 2);
      t_mask = 2'b01;
      run_xfer("wrap", 0);
      check("wrap_second_read_addr", seen.size() > 2 ? seen[2].addr : 32'hDEAD, 32'h0);

      // Start re-pulsed while busy must be ignored
      set_ch(0, 32'hB00, 32'hC00, 4);
      t_mask = 2'b01;
      run_xfer("restart_ignored", 4);

      // Reset while a write waits for its ack
      do_reset();
      ack_wr_en = 1'b0;
      @(negedge clk);
      ch_start = 2'b01;
      ch_src[0 +: ADDR_W] = 32'h200;
      ch_dst[0 +: ADDR_W] = 32'h300;
      ch_len[0 +: LEN_W]  = LEN_W'(3);
      reached_wr = 1'b0;
      for (int i = 0; i < 50 && !reached_wr; i++) begin
         @(negedge clk);
         ch_start = '0;
         if (mem_req && mem_we) reached_wr = 1'b1;
      end
      check("abort_reached_wr", reached_wr, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", ch_busy, '0);
      check("abort_req", mem_req, 1'b0);
      check("abort_done", ch_done, '0);
      reset     = 1'b0;
      ack_wr_en = 1'b1;
      m_last    = NUM_CH - 1;
      dones      = 0;
      req_cycles = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ch_done != '0) dones++;
         if (mem_req) req_cycles++;
      end
      check("abort_no_done_after", dones, 0);
      check("abort_stays_idle", req_cycles, 0);
      set_ch(0, 32'h200, 32'h300, 3);
      t_mask = 2'b01;
      run_xfer("after_abort", 0);

      // Randomized transfers with random ack latency
      max_delay = 2;
      for (int r = 0; r < 8; r++) begin
         t_mask = NUM_CH'($urandom_range((1 << NUM_CH) - 1, 0));
         for (int c = 0; c < NUM_CH; c++)
            set_ch(c, $urandom, $urandom, int'($urandom_range(5, 0)));
         run_xfer($sformatf("rand%0d", r), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
